bridge_router: RTL and testbench

// Registered, parametrised APF bridge address router. It sits between the host bridge and N leaf

---
 rtl/bridge_router_pkg.sv | 23 ++
 rtl/bridge_router_if.sv | 21 ++
 rtl/bridge_router_addr_decode.sv | 32 +++
 rtl/bridge_router.sv | 118 +++++++++++
 tb/tb_bridge_router.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_router_pkg.sv
// Shared types for the APF bridge router: address ranges, leaf index and the
// read-tracker entry carried down the return pipe.
package pocket;

    typedef struct packed {
        logic [31:0] from_addr;
        logic [31:0] to_addr;
    } bridge_addr_range_t;

    typedef logic [3:0] leaf_idx_t;

    typedef struct packed {
        logic      valid;
        leaf_idx_t idx;
        logic      unmapped;
    } trk_entry_t;

    localparam logic [31:0]        BRIDGE_UNMAPPED_DEFAULT = 32'hDEAD_BEEF;
    localparam int                 BRIDGE_MAX_LEAVES       = 16;
    localparam bridge_addr_range_t BRIDGE_RANGE_DEFAULT    = '{from_addr: 32'hFFFF_0000,
                                                               to_addr:   32'hFFFF_00FF};

endpackage

// File: rtl/bridge_router_if.sv
// Host-side bridge bus: address, one-cycle write/read strobes, write data and
// the registered read return.
interface bridge_router_if;

    logic [31:0] host_addr;
    logic        host_wr;
    logic [31:0] host_wr_data;
    logic        host_rd;
    logic [31:0] host_rd_data;

    modport master (
        output host_addr, host_wr, host_wr_data, host_rd,
        input  host_rd_data
    );

    modport slave (
        input  host_addr, host_wr, host_wr_data, host_rd,
        output host_rd_data
    );

endinterface

// File: rtl/bridge_router_addr_decode.sv
// Combinational inclusive-range address decoder; on overlap the lowest leaf
// index wins.
module bridge_addr_decode
    import pocket::*;
#(
    parameter int                 NUM_LEAVES              = 6,
    parameter bridge_addr_range_t ADDR_RANGES [NUM_LEAVES] = '{default: BRIDGE_RANGE_DEFAULT}
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output leaf_idx_t             idx,
    output logic [NUM_LEAVES-1:0] sel
);

    // NOTE: every output gets a default before the loops so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scan downwards so the lowest matching leaf is the last one to win.
        for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
            if (addr >= ADDR_RANGES[i].from_addr && addr <= ADDR_RANGES[i].to_addr) begin
                hit = 1'b1;
                idx = leaf_idx_t'(i);
            end
        end
        sel = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            sel[i] = hit && (idx == leaf_idx_t'(i));
        end
    end

endmodule

// File: rtl/bridge_router.sv
// Registered APF bridge router: forwards host strobes to the decoded leaf,
// pipes read returns back in order and logs unmapped/illegal accesses.
module bridge_router
    import pocket::*;
#(
    parameter int                 NUM_LEAVES               = 6,
    parameter bridge_addr_range_t ADDR_RANGES [NUM_LEAVES] = '{default: BRIDGE_RANGE_DEFAULT},
    parameter logic               ENDIAN_LITTLE            = 1'b0,
    parameter int                 RD_LATENCY               = 1,
    parameter logic [31:0]        UNMAPPED_DATA            = BRIDGE_UNMAPPED_DEFAULT
) (
    input  logic                        clk_74a,
    input  logic                        reset_n,
    bridge_router_if.slave              host,
    output logic                        bridge_endian_little,
    output logic [31:0]                 leaf_addr,
    output logic [31:0]                 leaf_wr_data,
    output logic [NUM_LEAVES-1:0]       leaf_wr,
    output logic [NUM_LEAVES-1:0]       leaf_rd,
    input  logic [NUM_LEAVES-1:0][31:0] leaf_rd_data,
    output logic [15:0]                 unmapped_count,
    output logic [31:0]                 last_unmapped_addr
);

    if (NUM_LEAVES < 1 || NUM_LEAVES > BRIDGE_MAX_LEAVES) begin : g_bad_num_leaves
        $error("bridge_router: NUM_LEAVES=%0d outside 1..16", NUM_LEAVES);
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
        $error("bridge_router: RD_LATENCY=%0d outside 1..4", RD_LATENCY);
    end
    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_range_chk
        if (ADDR_RANGES[g].from_addr > ADDR_RANGES[g].to_addr) begin : g_bad_range
            $error("bridge_router: leaf %0d has from_addr > to_addr", g);
        end
    end

    assign bridge_endian_little = ENDIAN_LITTLE;

    logic                  dec_hit;
    leaf_idx_t             dec_idx;
    logic [NUM_LEAVES-1:0] dec_sel;

    bridge_addr_decode #(
        .NUM_LEAVES  (NUM_LEAVES),
        .ADDR_RANGES (ADDR_RANGES)
    ) u_decode (
        .addr (host.host_addr),
        .hit  (dec_hit),
        .idx  (dec_idx),
        .sel  (dec_sel)
    );

    // A simultaneous write+read is illegal: the write wins and the access is logged.
    logic any_strobe, rd_only, log_unmapped;
    assign any_strobe   = host.host_wr || host.host_rd;
    assign rd_only      = host.host_rd && !host.host_wr;
    assign log_unmapped = any_strobe && (!dec_hit || (host.host_wr && host.host_rd));

    trk_entry_t  s1_entry;
    trk_entry_t  trk [RD_LATENCY];
    trk_entry_t  head;
    logic [31:0] head_data;

    assign head = trk[RD_LATENCY-1];

    always_comb begin
        head_data = UNMAPPED_DATA;
        if (!head.unmapped) begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (head.idx == leaf_idx_t'(i)) head_data = leaf_rd_data[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes the tracker shift correctly.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            leaf_addr    <= '0;
            leaf_wr_data <= '0;
            leaf_wr      <= '0;
            leaf_rd      <= '0;
        end else begin
            if (any_strobe) begin
                leaf_addr    <= host.host_addr;
                leaf_wr_data <= host.host_wr_data;
            end
            leaf_wr <= (host.host_wr && dec_hit) ? dec_sel : '0;
            leaf_rd <= (rd_only && dec_hit) ? dec_sel : '0;
        end
    end

    // NOTE: the tracker is a handful of flops, not a RAM, so it is fully reset;
    // that is what drops an in-flight read on reset.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            s1_entry          <= '0;
            for (int i = 0; i < RD_LATENCY; i++) trk[i] <= '0;
            host.host_rd_data <= '0;
        end else begin
            s1_entry <= '{valid: rd_only, idx: dec_idx, unmapped: !dec_hit};
            trk[0]   <= s1_entry;
            for (int i = 1; i < RD_LATENCY; i++) trk[i] <= trk[i-1];
            if (head.valid) host.host_rd_data <= head_data;
        end
    end

    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            unmapped_count     <= '0;
            last_unmapped_addr <= '0;
        end else if (log_unmapped) begin
            if (unmapped_count != 16'hFFFF) unmapped_count <= unmapped_count + 16'd1;
            last_unmapped_addr <= host.host_addr;
        end
    end

endmodule

// File: tb/tb_bridge_router.sv
// Bench for bridge_router: vector table for decode/strobe behaviour, a
// scoreboard for read returns, and hand sequences for pipelining, reset and saturation.
module tb_bridge_router;
    import pocket::*;

    localparam int NL  = 6;
    localparam int RDL = 1;
    localparam bridge_addr_range_t RANGES [NL] = '{
        '{32'hF800_0000, 32'hF800_1FFF},
        '{32'hF800_2000, 32'hF800_20FF},
        '{32'h0000_0000, 32'h000F_FFFF},
        '{32'h1000_0000, 32'h1000_0052},
        '{32'h2000_0000, 32'h2000_000F},
        '{32'hF800_1000, 32'hF800_1FFF}
    };

    logic                 clk_74a = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 bridge_endian_little;
    logic [31:0]          leaf_addr, leaf_wr_data, last_unmapped_addr;
    logic [NL-1:0]        leaf_wr, leaf_rd;
    logic [NL-1:0][31:0]  leaf_rd_data = '0;
    logic [15:0]          unmapped_count;

    bridge_router_if bus ();

    bridge_router #(
        .NUM_LEAVES    (NL),
        .ADDR_RANGES   (RANGES),
        .ENDIAN_LITTLE (1'b0),
        .RD_LATENCY    (RDL),
        .UNMAPPED_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk_74a              (clk_74a),
        .reset_n              (reset_n),
        .host                 (bus),
        .bridge_endian_little (bridge_endian_little),
        .leaf_addr            (leaf_addr),
        .leaf_wr_data         (leaf_wr_data),
        .leaf_wr              (leaf_wr),
        .leaf_rd              (leaf_rd),
        .leaf_rd_data         (leaf_rd_data),
        .unmapped_count       (unmapped_count),
        .last_unmapped_addr   (last_unmapped_addr)
    );

    always #5 clk_74a = ~clk_74a;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    always @(posedge clk_74a) cyc <= cyc + 1;

    // Leaf models: data valid one cycle after the read strobe.
    function automatic logic [31:0] leaf_val(input int i, input logic [31:0] a);
        if (i == 3) return 32'hA5A5_A5A5;
        return {4'hC, 4'(i), a[23:0]};
    endfunction

    always @(posedge clk_74a) begin
        for (int i = 0; i < NL; i++)
            if (leaf_rd[i]) leaf_rd_data[i] <= leaf_val(i, leaf_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic [31:0] data;
    } sb_t;
    sb_t         sb [$];
    logic [31:0] last_rd = '0;

    task automatic push_exp(input logic [31:0] data);
        sb_t e;
        e.due  = cyc + 2 + RDL;
        e.data = data;
        sb.push_back(e);
    endtask

    always @(negedge clk_74a) begin : sb_mon
        sb_t e;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rd_return", bus.host_rd_data, e.data);
            last_rd = e.data;
        end
    end

    task automatic drive(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
        @(posedge clk_74a); #1;
        bus.host_addr    = a;
        bus.host_wr      = w;
        bus.host_rd      = r;
        bus.host_wr_data = d;
    endtask

    task automatic idle();
        @(posedge clk_74a); #1;
        bus.host_wr = 1'b0;
        bus.host_rd = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic [5:0]  exp_wr;
        logic [5:0]  exp_rd;
        logic        exp_unm;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t        vecs [NV];
    vec_t        v;
    logic [15:0] exp_cnt  = '0;
    logic [31:0] exp_last = '0;

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = '{
            '{32'hF800_0010, 1'b1, 1'b0, 32'h1234_5678, 6'b000001, 6'b000000, 1'b0, 32'h0},
            '{32'h1000_0052, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b001000, 1'b0, 32'hA5A5_A5A5},
            '{32'h1000_0053, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b000000, 1'b1, 32'hDEAD_BEEF},
            '{32'hF800_2000, 1'b1, 1'b0, 32'hCAFE_F00D, 6'b000010, 6'b000000, 1'b0, 32'h0},
            '{32'hF800_20FF, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b000010, 1'b0, 32'hC100_20FF},
            '{32'hF800_2100, 1'b1, 1'b0, 32'h0BAD_0BAD, 6'b000000, 6'b000000, 1'b1, 32'h0},
            '{32'h000F_FFFF, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b000100, 1'b0, 32'hC20F_FFFF},
            '{32'h0010_0000, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b000000, 1'b1, 32'hDEAD_BEEF},
            '{32'hF800_1800, 1'b1, 1'b0, 32'h1111_2222, 6'b000001, 6'b000000, 1'b0, 32'h0},
            '{32'hF800_1FFF, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b000001, 1'b0, 32'hC000_1FFF},
            '{32'h2000_000F, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b010000, 1'b0, 32'hC400_000F},
            '{32'hF7FF_FFFF, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b000000, 1'b1, 32'hDEAD_BEEF},
            '{32'hF800_0000, 1'b0, 1'b1, 32'h0,         6'b000000, 6'b000001, 1'b0, 32'hC000_0000}
        };

        bus.host_addr    = '0;
        bus.host_wr      = 1'b0;
        bus.host_rd      = 1'b0;
        bus.host_wr_data = '0;

        // Reset state.
        repeat (3) @(posedge clk_74a);
        #1;
        check("rst_leaf_wr",   32'(leaf_wr), 32'h0);
        check("rst_leaf_rd",   32'(leaf_rd), 32'h0);
        check("rst_leaf_addr", leaf_addr, 32'h0);
        check("rst_leaf_wdat", leaf_wr_data, 32'h0);
        check("rst_rd_data",   bus.host_rd_data, 32'h0);
        check("rst_count",     32'(unmapped_count), 32'h0);
        check("rst_last",      last_unmapped_addr, 32'h0);
        check("endian",        32'(bridge_endian_little), 32'h0);
        reset_n = 1'b1;

        // Table-driven decode / strobe / logging vectors.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            drive(v.addr, v.wr, v.rd, v.wdata);
            if (v.rd && !v.wr) push_exp(v.exp_rdata);
            if (v.exp_unm) begin
                exp_cnt  = exp_cnt + 16'd1;
                exp_last = v.addr;
            end
            idle();
            check($sformatf("v%0d_leaf_wr", i),   32'(leaf_wr), 32'(v.exp_wr));
            check($sformatf("v%0d_leaf_rd", i),   32'(leaf_rd), 32'(v.exp_rd));
            check($sformatf("v%0d_leaf_addr", i), leaf_addr, v.addr);
            if (v.wr) check($sformatf("v%0d_leaf_wdat", i), leaf_wr_data, v.wdata);
            check($sformatf("v%0d_count", i), 32'(unmapped_count), 32'(exp_cnt));
            check($sformatf("v%0d_last", i),  last_unmapped_addr, exp_last);
            @(posedge clk_74a); #1;
            check($sformatf("v%0d_wr_pulse", i), 32'(leaf_wr), 32'h0);
            check($sformatf("v%0d_rd_pulse", i), 32'(leaf_rd), 32'h0);
        end

        // Back-to-back reads to L0, L2, L1.
        drive(32'hF800_0100, 1'b0, 1'b1, 32'h0); push_exp(32'hC000_0100);
        drive(32'h0000_0200, 1'b0, 1'b1, 32'h0); push_exp(32'hC200_0200);
        drive(32'hF800_2010, 1'b0, 1'b1, 32'h0); push_exp(32'hC100_2010);
        idle();
        repeat (6) @(posedge clk_74a);
        #1;
        check("b2b_drained", sb.size(), 32'h0);

        // Simultaneous write and read: write forwarded, read dropped and logged.
        drive(32'h0000_0004, 1'b1, 1'b1, 32'h5555_AAAA);
        exp_cnt  = exp_cnt + 16'd1;
        exp_last = 32'h0000_0004;
        idle();
        check("wrrd_leaf_wr", 32'(leaf_wr), 32'h04);
        check("wrrd_leaf_rd", 32'(leaf_rd), 32'h0);
        check("wrrd_count",   32'(unmapped_count), 32'(exp_cnt));
        check("wrrd_last",    last_unmapped_addr, exp_last);
        repeat (4) begin
            @(posedge clk_74a); #1;
            check("wrrd_no_rd",   32'(leaf_rd), 32'h0);
            check("wrrd_rd_hold", bus.host_rd_data, last_rd);
        end

        // Reset while a read is in flight: it must be dropped.
        drive(32'h0000_0300, 1'b0, 1'b1, 32'h0);
        idle();
        @(posedge clk_74a); #1;
        reset_n = 1'b0;
        @(posedge clk_74a); #1;
        check("rst_flight_rd_data", bus.host_rd_data, 32'h0);
        check("rst_flight_count",   32'(unmapped_count), 32'h0);
        reset_n = 1'b1;
        repeat (4) begin
            @(posedge clk_74a); #1;
            check("rst_no_late_update", bus.host_rd_data, 32'h0);
        end

        // Saturation of the unmapped counter.
        drive(32'h3000_0000, 1'b1, 1'b0, 32'h0);
        repeat (65534) @(posedge clk_74a);
        #1;
        check("sat_fffe", 32'(unmapped_count), 32'h0000_FFFE);
        repeat (4000) @(posedge clk_74a);
        #1;
        bus.host_wr = 1'b0;
        check("sat_ffff", 32'(unmapped_count), 32'h0000_FFFF);
        check("sat_last", last_unmapped_addr, 32'h3000_0000);
        @(posedge clk_74a); #1;
        check("sat_hold", 32'(unmapped_count), 32'h0000_FFFF);

        repeat (4) @(posedge clk_74a);
        #1;
        check("sb_empty", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
